// File: rtl/control_unit_if.sv
// Control bus between the control_unit and the ROM/ALU/RAM datapath.
// The control unit is the master: it consumes the fetched instruction and
// ALU flags and drives the control word, the immediate and its status.
interface control_unit_if;
    logic [31:0] instruction;
    logic [3:0]  status;
    logic [31:0] control_word;
    logic [63:0] k;
    logic [2:0]  state;
    logic        halted;

    modport master (
        input  instruction,
        input  status,
        output control_word,
        output k,
        output state,
        output halted
    );

    modport slave (
        output instruction,
        output status,
        input  control_word,
        input  k,
        input  state,
        input  halted
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle LEGv8-subset decoder and sequencer (FETCH/DECODE/EXEC/MEM/HALT).
// Latches the ROM instruction at the end of FETCH and drives the datapath
// control word and constant k each cycle. control_word layout, MSB first:
// {0, PS[1:0], DA, SA, SB, FS, regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC,
//  selB, PCsel, SL}.
module control_unit (
    input  logic          clock,
    input  logic          reset,
    control_unit_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALT   = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_ORR,
        OP_ADDI,
        OP_SUBI,
        OP_LDUR,
        OP_STUR,
        OP_B,
        OP_CBZ,
        OP_HALT
    } op_t;

    localparam logic [4:0] FS_AND    = 5'b00000;
    localparam logic [4:0] FS_ORR    = 5'b00100;
    localparam logic [4:0] FS_ADD    = 5'b01000;
    localparam logic [4:0] FS_SUB    = 5'b01001;
    localparam logic [4:0] FS_PASS_B = 5'b01100;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_NEXT   = 2'b01;
    localparam logic [1:0] PS_BRANCH = 2'b10;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] ir_q;

    op_t         op;
    logic [4:0]  op_fs;
    logic [4:0]  sb_field;
    logic [63:0] k_val;

    logic [1:0]  ps;
    logic [4:0]  fs;
    logic        reg_w_raw;
    logic        reg_w;
    logic        ram_w;
    logic        en_mem;
    logic        en_alu;
    logic        en_b;
    logic        en_pc;
    logic        sel_b;
    logic        pc_sel;
    logic        sl;
    logic        show_fields;
    logic        halted_int;

    logic [4:0]  da_out;
    logic [4:0]  sa_out;
    logic [4:0]  sb_out;

    // Only the zero flag steers branches; the other ALU flags are ignored.
    logic        unused_flags;
    assign unused_flags = ^bus.status[3:1];

    // State and instruction register; IR only captures the ROM word in FETCH.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                ir_q <= bus.instruction;
            end
        end
    end

    // Opcode classification of the latched instruction.
    always_comb begin
        op = OP_NOP;
        if (ir_q == '0) begin
            op = OP_HALT;
        end else if (ir_q[31:21] == 11'b10001011000) begin
            op = OP_ADD;
        end else if (ir_q[31:21] == 11'b11001011000) begin
            op = OP_SUB;
        end else if (ir_q[31:21] == 11'b10001010000) begin
            op = OP_AND;
        end else if (ir_q[31:21] == 11'b10101010000) begin
            op = OP_ORR;
        end else if (ir_q[31:22] == 10'b1001000100) begin
            op = OP_ADDI;
        end else if (ir_q[31:22] == 10'b1101000100) begin
            op = OP_SUBI;
        end else if (ir_q[31:21] == 11'b11111000010) begin
            op = OP_LDUR;
        end else if (ir_q[31:21] == 11'b11111000000) begin
            op = OP_STUR;
        end else if (ir_q[31:26] == 6'b000101) begin
            op = OP_B;
        end else if (ir_q[31:24] == 8'b10110100) begin
            op = OP_CBZ;
        end
    end

    // ALU function, SB source and immediate for the decoded opcode.
    always_comb begin
        op_fs    = FS_AND;
        sb_field = '0;
        k_val    = '0;
        unique case (op)
            OP_ADD: begin
                op_fs    = FS_ADD;
                sb_field = ir_q[20:16];
            end
            OP_SUB: begin
                op_fs    = FS_SUB;
                sb_field = ir_q[20:16];
            end
            OP_AND: begin
                op_fs    = FS_AND;
                sb_field = ir_q[20:16];
            end
            OP_ORR: begin
                op_fs    = FS_ORR;
                sb_field = ir_q[20:16];
            end
            OP_ADDI: begin
                op_fs = FS_ADD;
                k_val = {52'd0, ir_q[21:10]};
            end
            OP_SUBI: begin
                op_fs = FS_SUB;
                k_val = {52'd0, ir_q[21:10]};
            end
            OP_LDUR: begin
                op_fs = FS_ADD;
                k_val = {{55{ir_q[20]}}, ir_q[20:12]};
            end
            OP_STUR: begin
                op_fs    = FS_ADD;
                sb_field = ir_q[4:0];
                k_val    = {{55{ir_q[20]}}, ir_q[20:12]};
            end
            OP_B: begin
                k_val = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
            end
            OP_CBZ: begin
                op_fs    = FS_PASS_B;
                sb_field = ir_q[4:0];
                k_val    = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
            end
            default: begin
            end
        endcase
    end

    // Next-state sequencing; only LDUR takes the extra MEM cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = (ir_q == '0) ? HALT : EXEC;
            EXEC:    state_d = (op == OP_LDUR) ? MEM : FETCH;
            MEM:     state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Per-state control outputs; CBZ's PC select is the one path from status.
    always_comb begin
        ps          = PS_HOLD;
        fs          = FS_AND;
        reg_w_raw   = 1'b0;
        ram_w       = 1'b0;
        en_mem      = 1'b0;
        en_alu      = 1'b0;
        en_b        = 1'b0;
        sel_b       = 1'b0;
        pc_sel      = 1'b0;
        sl          = 1'b0;
        show_fields = 1'b0;
        halted_int  = 1'b0;
        unique case (state_q)
            FETCH: begin
            end
            DECODE: begin
                show_fields = 1'b1;
            end
            EXEC: begin
                show_fields = 1'b1;
                unique case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                        fs        = op_fs;
                        en_b      = 1'b1;
                        en_alu    = 1'b1;
                        reg_w_raw = 1'b1;
                        ps        = PS_NEXT;
                    end
                    OP_ADDI, OP_SUBI: begin
                        fs        = op_fs;
                        sel_b     = 1'b1;
                        en_alu    = 1'b1;
                        reg_w_raw = 1'b1;
                        ps        = PS_NEXT;
                    end
                    OP_STUR: begin
                        fs     = FS_ADD;
                        sel_b  = 1'b1;
                        en_alu = 1'b1;
                        en_mem = 1'b1;
                        ram_w  = 1'b1;
                        ps     = PS_NEXT;
                    end
                    OP_LDUR: begin
                        fs     = FS_ADD;
                        sel_b  = 1'b1;
                        en_alu = 1'b1;
                        en_mem = 1'b1;
                    end
                    OP_B: begin
                        pc_sel = 1'b1;
                        ps     = PS_BRANCH;
                    end
                    OP_CBZ: begin
                        fs     = FS_PASS_B;
                        en_b   = 1'b1;
                        en_alu = 1'b1;
                        pc_sel = 1'b1;
                        ps     = bus.status[0] ? PS_BRANCH : PS_NEXT;
                    end
                    default: begin
                        ps = PS_NEXT;
                    end
                endcase
            end
            MEM: begin
                show_fields = 1'b1;
                en_mem      = 1'b1;
                en_alu      = 1'b1;
                sl          = 1'b1;
                reg_w_raw   = 1'b1;
                ps          = PS_NEXT;
            end
            HALT: begin
                halted_int = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // X31 is the zero register: writes to it are dropped, PC still advances.
    assign reg_w  = reg_w_raw && (ir_q[4:0] != 5'd31);
    assign en_pc  = (ps != PS_HOLD);

    assign da_out = show_fields ? ir_q[4:0] : '0;
    assign sa_out = show_fields ? ir_q[9:5] : '0;
    assign sb_out = show_fields ? sb_field  : '0;

    assign bus.control_word = {1'b0, ps, da_out, sa_out, sb_out, fs,
                               reg_w, ram_w, en_mem, en_alu, en_b, en_pc,
                               sel_b, pc_sel, sl};
    assign bus.k            = show_fields ? k_val : '0;
    assign bus.state        = state_q;
    assign bus.halted       = halted_int;

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction decoder and sequencer sitting directly upstream of the ROM datapath. Each cycle it drives the datapath's 32-bit control word and 64-bit constant `k`. It latches the ROM's instruction into an instruction register, steps a FETCH/DECODE/EXEC/MEM state machine, and resolves conditional branches from the ALU status flags. Supports the LEGv8 subset ADD, SUB, AND, ORR, ADDI, SUBI, LDUR, STUR, B, CBZ, plus HALT.

## Interface
- No parameters.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `instruction`  in  32  ROM output at the current PC.
- `status`  in  4  ALU flags {V,C,N,Z}; Z = status[0].
- `control_word`  out  32  {1'b0, PS[1:0], DA[4:0], SA[4:0], SB[4:0], FS[4:0], regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, selB, PCsel, SL}; bit 31 is reserved 0.
- `k`  out  64  immediate / branch offset for the datapath.
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4.
- `halted`  out  1  high while in HALT.

## Operation
- **IR** is loaded from `instruction` only at the end of FETCH and holds through the rest of the instruction.
- **Decode from IR[31:21]:**
  - ADD 10001011000; SUB 11001011000; AND 10001010000; ORR 10101010000.
  - ADDI IR[31:22]=1001000100; SUBI 1101000100.
  - LDUR 11111000010; STUR 11111000000.
  - B IR[31:26]=000101; CBZ IR[31:24]=10110100.
  - HALT IR=32'h0. Anything else is a NOP.
- **Register fields:** DA=IR[4:0], SA=IR[9:5], SB=IR[20:16] (R-type), SB=IR[4:0] (STUR, CBZ).
- **FS encoding:** AND 00000, ORR 00100, ADD 01000, SUB 01001, PASS_B 01100.
- **PS encoding:** 00 hold, 01 PC+4, 10 PC+(k), 11 reserved (never driven).
- **EN_PC rule:** EN_PC = (PS != 00) in every state.
- **k generation:**
  - ADDI/SUBI: zero-extend IR[21:10].
  - LDUR/STUR: sign-extend IR[20:12].
  - B: sign-extend IR[25:0], then <<2.
  - CBZ: sign-extend IR[23:5], then <<2.
  - Otherwise k=0.
- **FETCH:** all write/enable bits 0, PS=00. Next state DECODE.
- **DECODE:** fields and k valid; all writes 0, PS=00.
  - Next state HALT if IR=0, else EXEC.
- **EXEC** (one active cycle, then next state):
  - R-type: FS per op, EN_B=1, EN_ALU=1, regW=1, PS=01. Next FETCH.
  - ADDI/SUBI: FS=ADD/SUB, selB=1, EN_ALU=1, regW=1, PS=01. Next FETCH.
  - STUR: FS=ADD, selB=1, EN_ALU=1, EN_MEM=1, ramW=1, PS=01, regW=0. Next FETCH.
  - LDUR: FS=ADD, selB=1, EN_ALU=1, EN_MEM=1, no writes, PS=00. Next MEM.
  - B: PCsel=1, PS=10, no writes. Next FETCH.
  - CBZ: FS=PASS_B, EN_B=1, EN_ALU=1, PCsel=1.
    - PS = status[0] ? 10 : 01. This is the only combinational input-to-output path.
    - Next FETCH.
  - NOP: PS=01, no writes. Next FETCH.
- **MEM** (LDUR only): EN_MEM=1, EN_ALU=1, SL=1 (write data from RAM), regW=1, PS=01. Next FETCH.
- **HALT:** all outputs idle, PS=00, halted=1. Stays in HALT until reset.
- **Register-write guard:** regW is never asserted when DA=31 (XZR). The write is suppressed; PS still advances.

## Timing
- **Reset** (sampled on the rising edge):
  - state=FETCH, IR=0, halted=0.
  - control_word=0, k=0 on the following cycle.
  - Reset mid-instruction aborts the instruction with no partial write.
- All outputs are combinational from the registered state/IR, except CBZ PS (also depends on `status`).
- **Instruction latency:**
  - ALU/imm/store/branch/NOP: 3 cycles (FETCH, DECODE, EXEC).
  - LDUR: 4 cycles.
- Exactly one cycle per instruction has EN_PC=1; regW and ramW are never high together.
- `instruction` must be stable before the FETCH rising edge. Changes outside FETCH are ignored.

## Test plan
- **Reset:** assert reset for 2 cycles mid-EXEC of ADD → state=0, control_word=0, regW never pulses after reset.
- **ADD X3,X1,X2** (32'h8B020023) → DECODE then EXEC with DA=3, SA=1, SB=2, FS=01000, regW=1, EN_B=1, PS=01, EN_PC=1. Back in FETCH on cycle 3.
- **ADDI X5,X0,#4095** (32'h913FFC05) → k=64'h0FFF, selB=1, regW=1. **LDUR X7,[X1,#-8]** (32'hF85F8027) → k=64'hFFFF_FFFF_FFFF_FFF8, MEM cycle with SL=1, regW=1, total 4 cycles.
- **CBZ X4,#+2** (32'hB4000044) → k=64'h8. With status=4'b0001: PS=10. With status=0: PS=01.
- **B #-1** (32'h17FFFFFF) → k=64'hFFFF_FFFF_FFFF_FFFC, PS=10, no writes.
- **Boundary cases:**
  - ADD to X31 → regW=0, PS=01.
  - Undefined opcode 32'hFFFFFFFF → NOP, PS=01.
  - 32'h0 → HALT, halted=1 for 10+ cycles with PS=00, until reset returns state to FETCH.
